// File: rtl/fifo_ser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_ser_pkg : shared types and helpers for fifo_word_serializer      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package fifo_ser_pkg;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_t;

  function automatic int beats(input int dw, input int ow);
    return dw / ow;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_word_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_word_serializer_if : FIFO read side plus narrow output stream    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface fifo_word_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_empty;
  logic                  fifo_poll;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  busy;

  // serializer side
  modport master (
    input  fifo_head, fifo_empty, out_ready,
    output fifo_poll, out_data, out_valid, out_last, busy
  );

  // environment side: FIFO and downstream sink
  modport slave (
    output fifo_head, fifo_empty, out_ready,
    input  fifo_poll, out_data, out_valid, out_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_word_serializer : pops FIFO words and emits them as narrow beats |
// | Option macro: FIFO_SER_MSB_FIRST_EN (MSB-first beat order)            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2
) (
  input  wire                   clk,
  input  wire                   rst,
  fifo_word_serializer_if.master bus
);

  localparam int BEATS = beats(DATA_WIDTH, OUT_WIDTH);
  localparam int CNT_W = (BEATS > 2) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  generate
    if ((OUT_WIDTH < 1) || (DATA_WIDTH % OUT_WIDTH != 0) || (BEATS < 2)) begin : g_bad_cfg
      $error("fifo_word_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH with at least 2 beats");
    end
  endgenerate

  ser_state_t            state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt, shift_adv;
  logic [CNT_W-1:0]      beat_cnt, cnt_nxt;
  logic                  poll_req;
  logic [OUT_WIDTH-1:0]  cur_slice;

`ifdef FIFO_SER_MSB_FIRST_EN
  assign cur_slice = shift_reg[DATA_WIDTH-1 -: OUT_WIDTH];
  assign shift_adv = shift_reg << OUT_WIDTH;
`else
  assign cur_slice = shift_reg[OUT_WIDTH-1:0];
  assign shift_adv = shift_reg >> OUT_WIDTH;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SER_IDLE;
      shift_reg <= '0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      beat_cnt  <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = beat_cnt;
    poll_req  = 1'b0;
    case (state)
      SER_IDLE: begin
        if (!bus.fifo_empty) begin
          poll_req  = 1'b1;
          shift_nxt = bus.fifo_head;
          cnt_nxt   = '0;
          state_nxt = SER_SEND;
        end
      end
      SER_SEND: begin
        if (bus.out_ready) begin
          if (beat_cnt != LAST_BEAT) begin
            shift_nxt = shift_adv;
            cnt_nxt   = beat_cnt + CNT_W'(1);
          end else if (!bus.fifo_empty) begin
            // chain straight into the next word so the stream has no bubble
            poll_req  = 1'b1;
            shift_nxt = bus.fifo_head;
            cnt_nxt   = '0;
          end else begin
            shift_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = SER_IDLE;
          end
        end
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

  assign bus.fifo_poll = poll_req & ~rst;
  assign bus.out_valid = (state == SER_SEND);
  assign bus.busy      = (state == SER_SEND);
  assign bus.out_data  = (state == SER_SEND) ? cur_slice : '0;
  assign bus.out_last  = (state == SER_SEND) && (beat_cnt == LAST_BEAT);

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_word_serializer : queue-modelled FIFO driving the serializer  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_fifo_word_serializer;
  localparam int DW    = 8;
  localparam int OW    = 2;
  localparam int BEATS = DW / OW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_word_serializer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

  fifo_word_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] fq[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] seen[$];
  int            rem;
  int            checks = 0;
  int            errors = 0;
  int            poll_cnt;

`ifdef FIFO_SER_MSB_FIRST_EN
  logic [OW-1:0] e_b4[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [OW-1:0] e_1e[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
`else
  logic [OW-1:0] e_b4[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [OW-1:0] e_1e[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
`endif

  function automatic logic [OW-1:0] slice_of(input logic [DW-1:0] w, input int i);
`ifdef FIFO_SER_MSB_FIRST_EN
    return OW'((w >> ((BEATS - 1 - i) * OW)) & ((1 << OW) - 1));
`else
    return OW'((w >> (i * OW)) & ((1 << OW) - 1));
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_head  = (fq.size() == 0) ? '0 : fq[0];
  endtask

  // one clock: check outputs against the model, then advance FIFO and model
  task automatic step();
    logic exp_poll, acc;
    logic [DW-1:0] w;
    refresh();
    @(negedge clk);
    exp_poll = !rst && (fq.size() != 0) && (rem == 0 || (rem == 1 && bus.out_ready));
    acc      = !rst && (rem != 0) && bus.out_ready;
    chk("poll",  32'(bus.fifo_poll), 32'(exp_poll));
    chk("valid", 32'(bus.out_valid), 32'(rem != 0));
    chk("busy",  32'(bus.busy),      32'(rem != 0));
    chk("last",  32'(bus.out_last),  32'(rem == 1));
    chk("data",  32'(bus.out_data),  (rem != 0) ? 32'(exp_q[0]) : 32'd0);
    if (bus.fifo_poll) poll_cnt++;
    if (acc) seen.push_back(bus.out_data);
    @(posedge clk);
    #1;
    if (rst) begin
      rem = 0;
      exp_q.delete();
    end else begin
      if (acc) begin
        void'(exp_q.pop_front());
        rem--;
      end
      if (exp_poll) begin
        w = fq.pop_front();
        for (int i = 0; i < BEATS; i++) exp_q.push_back(slice_of(w, i));
        rem = BEATS;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    rem           = 0;
    poll_cnt      = 0;
    refresh();
    steps(2);
    rst = 1'b0;
    steps(10);

    // single word, sink always ready
    fq.push_back(8'hB4);
    bus.out_ready = 1'b1;
    seen.delete(); poll_cnt = 0;
    steps(8);
    chk("t2_polls", 32'(poll_cnt), 32'd1);
    chk("t2_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_beat%0d", i), 32'(seen[i]), 32'(e_b4[i]));

    // two words back to back
    fq.push_back(8'hB4); fq.push_back(8'h1E);
    seen.delete(); poll_cnt = 0;
    steps(12);
    chk("t3_polls", 32'(poll_cnt), 32'd2);
    chk("t3_count", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_w0_beat%0d", i), 32'(seen[i]),     32'(e_b4[i]));
      chk($sformatf("t3_w1_beat%0d", i), 32'(seen[i + 4]), 32'(e_1e[i]));
    end

    // stall on the first beat for 3 cycles
    fq.push_back(8'hB4);
    seen.delete();
    bus.out_ready = 1'b0;
    steps(4);
    bus.out_ready = 1'b1;
    steps(6);
    chk("t4_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_beat%0d", i), 32'(seen[i]), 32'(e_b4[i]));

    // reset mid-word with the next word queued
    fq.push_back(8'hB4); fq.push_back(8'h1E);
    seen.delete();
    steps(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(10);
    chk("t5_count", 32'(seen.size()), 32'd6);
    chk("t5_beat0", 32'(seen[0]), 32'(e_b4[0]));
    chk("t5_beat1", 32'(seen[1]), 32'(e_b4[1]));
    for (int i = 0; i < 4; i++) chk($sformatf("t5_w1_beat%0d", i), 32'(seen[i + 2]), 32'(e_1e[i]));

    // randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0 && fq.size() < 8) fq.push_back(DW'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    steps(40);
    chk("drain_fifo", 32'(fq.size()), 32'd0);
    chk("drain_idle", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
